// File: rtl/inst_queue_pkg.sv
// Shared types and sizing for the instruction queue between fetch and decode/issue.
package inst_queue_pkg;

  localparam int IQ_SIZE = 16;
  localparam int IQ_POS_W = 4;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;
  typedef logic [IQ_POS_W-1:0] iq_pos_t;
  typedef logic [IQ_POS_W:0] iq_cnt_t;

endpackage

// File: rtl/inst_queue.sv
// First-word fall-through instruction FIFO: fetch pushes {inst, pc, pred}, issue pops the head.
// Flush empties the queue in one cycle; rdy=0 freezes every register.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_SIZE,
  parameter int IQ_AW = IQ_POS_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            push_valid,
  input  inst_t           push_inst,
  input  addr_t           push_pc,
  input  logic            push_pred_jump,
  output logic            iq_full,
  output logic            head_valid,
  output inst_t           head_inst,
  output addr_t           head_pc,
  output logic            head_pred_jump,
  input  logic            pop,
  output logic [IQ_AW:0]  iq_count
);

  localparam logic [IQ_AW-1:0] PTR_ONE = {{(IQ_AW-1){1'b0}}, 1'b1};
  localparam logic [IQ_AW:0] CNT_ONE = {{IQ_AW{1'b0}}, 1'b1};
  localparam logic [IQ_AW:0] CNT_FULL = (IQ_AW+1)'(IQ_DEPTH);

  inst_t inst_mem [IQ_DEPTH];
  addr_t pc_mem [IQ_DEPTH];
  logic pred_mem [IQ_DEPTH];

  logic [IQ_AW-1:0] head_ptr;
  logic [IQ_AW-1:0] tail_ptr;
  logic [IQ_AW:0] count;
  logic [IQ_AW:0] next_count;
  logic push_fire;
  logic pop_fire;
  logic flush_fire;

  assign head_valid = (count != '0);
  assign flush_fire = flush & rdy;
  // The registered full flag gates push even when a pop fires in the same cycle.
  assign push_fire = push_valid & ~iq_full & rdy & ~flush;
  assign pop_fire = pop & head_valid & rdy & ~flush;

  always_comb begin
    next_count = count;
    if (flush_fire) begin
      next_count = '0;
    end else if (push_fire && !pop_fire) begin
      next_count = count + CNT_ONE;
    end else if (pop_fire && !push_fire) begin
      next_count = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count <= '0;
      iq_full <= 1'b0;
    end else if (rdy) begin
      count <= next_count;
      iq_full <= (next_count == CNT_FULL);
      if (flush_fire) begin
        head_ptr <= '0;
        tail_ptr <= '0;
      end else begin
        if (push_fire) tail_ptr <= tail_ptr + PTR_ONE;
        if (pop_fire) head_ptr <= head_ptr + PTR_ONE;
      end
    end
  end

  // Storage is not reset; head_valid gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      inst_mem[tail_ptr] <= push_inst;
      pc_mem[tail_ptr] <= push_pc;
      pred_mem[tail_ptr] <= push_pred_jump;
    end
  end

  assign head_inst = head_valid ? inst_mem[head_ptr] : '0;
  assign head_pc = head_valid ? pc_mem[head_ptr] : '0;
  assign head_pred_jump = head_valid ? pred_mem[head_ptr] : 1'b0;
  assign iq_count = count;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: driver tasks enqueue expected entries, a negedge monitor
// checks the head against the expected queue whenever a pop fires.
module tb_inst_queue;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  logic push_valid;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic push_pred_jump;
  logic iq_full;
  logic head_valid;
  logic [31:0] head_inst;
  logic [31:0] head_pc;
  logic head_pred_jump;
  logic pop;
  logic [4:0] iq_count;

  logic [64:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .flush(flush),
    .push_valid(push_valid),
    .push_inst(push_inst),
    .push_pc(push_pc),
    .push_pred_jump(push_pred_jump),
    .iq_full(iq_full),
    .head_valid(head_valid),
    .head_inst(head_inst),
    .head_pc(head_pc),
    .head_pred_jump(head_pred_jump),
    .pop(pop),
    .iq_count(iq_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input int exp_cnt);
    chk({name, "_count"}, 32'(iq_count), 32'(exp_cnt));
    chk({name, "_valid"}, 32'(head_valid), 32'(exp_cnt != 0));
    chk({name, "_full"}, 32'(iq_full), 32'(exp_cnt == 16));
  endtask

  // Drive one cycle's inputs just after the edge; model acceptance from the expected queue.
  task automatic cyc(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                     input logic pred, input logic pp, input logic fl, input logic r);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_inst = inst;
    push_pc = pc;
    push_pred_jump = pred;
    pop = pp;
    flush = fl;
    rdy = r;
    if (fl && r) exp_q.delete();
    else if (pv && r && exp_q.size() < 16) exp_q.push_back({pred, pc, inst});
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    cyc(1'b1, inst, pc, pred, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop1();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && rdy && !flush && pop && head_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_underflow: got head_pc %h, expected an empty queue", head_pc);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("head_inst", head_inst, e[31:0]);
        chk("head_pc", head_pc, e[63:32]);
        chk("head_pred", 32'(head_pred_jump), 32'(e[64]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    push_valid = 1'b0;
    push_inst = '0;
    push_pc = '0;
    push_pred_jump = 1'b0;
    pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_state("reset", 0);
    chk("reset_head_inst", head_inst, 32'h0);

    // Asynchronous reset in the middle of a cycle
    push(32'h1111_0001, 32'h10, 1'b0);
    push(32'h1111_0002, 32'h14, 1'b1);
    push(32'h1111_0003, 32'h18, 1'b0);
    idle();
    chk_state("pre_rst", 3);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 0);
    chk("async_rst_head_pc", head_pc, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // FIFO order
    push(32'h0050_0093, 32'h0, 1'b0);
    push(32'h00a0_0113, 32'h4, 1'b1);
    push(32'h0020_81b3, 32'h8, 1'b0);
    idle();
    chk_state("order_fill", 3);
    chk("order_head_inst", head_inst, 32'h0050_0093);
    repeat (3) pop1();
    idle();
    chk_state("order_drain", 0);

    // Fill, refuse, wrap
    for (int i = 0; i < 16; i++) push(32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'(i));
    push(32'hdead_beef, 32'hdead_0000, 1'b1);
    idle();
    chk_state("full", 16);
    repeat (4) pop1();
    for (int i = 16; i < 20; i++) push(32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'(i));
    idle();
    chk_state("wrap_full", 16);
    cyc(1'b1, 32'hbad0_0001, 32'hbad0_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    chk_state("full_push_pop", 15);
    chk("full_push_pop_head", head_pc, 32'h114);
    repeat (15) pop1();
    idle();
    chk_state("wrap_drain", 0);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push(32'h2000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0);
    idle();
    chk_state("five", 5);
    cyc(1'b1, 32'h2000_0005, 32'h214, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    chk_state("five_push_pop", 5);
    chk("five_head_pc", head_pc, 32'h204);

    // Flush wins over push and pop
    push(32'h2000_0006, 32'h218, 1'b0);
    push(32'h2000_0007, 32'h21c, 1'b1);
    idle();
    chk_state("seven", 7);
    cyc(1'b1, 32'h0000_feed, 32'h999, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    chk_state("flush", 0);
    push(32'h0000_0013, 32'h300, 1'b1);
    idle();
    chk("post_flush_head_pc", head_pc, 32'h300);
    chk_state("post_flush", 1);
    pop1();
    idle();
    chk_state("post_flush_drain", 0);

    // rdy=0 freezes everything
    push(32'h3000_0000, 32'h400, 1'b0);
    push(32'h3000_0001, 32'h404, 1'b1);
    idle();
    chk_state("pre_freeze", 2);
    repeat (3) cyc(1'b1, 32'h3000_00ff, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("freeze", 2);
    chk("freeze_head_pc", head_pc, 32'h400);
    cyc(1'b1, 32'h3000_0002, 32'h408, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk_state("resume", 2);
    chk("resume_head_pc", head_pc, 32'h404);
    repeat (2) pop1();
    idle();
    chk_state("final", 0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
